// File: rtl/pwm_fader_multi.sv
// Multi-channel PWM fader: one shared prescaled period counter, per-channel duty stepped
// in sawtooth/triangle fashion, held, or off. Define PWM_FADER_GAMMA_EN for a registered square-law gamma stage.
module pwm_fader_multi #(
    parameter int CH       = 4,
    parameter int R        = 8,
    parameter int STEP_DIV = 2_500_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   dvsr,
    input  logic [1:0]    mode,
    input  logic [R:0]    hold_duty,
    output logic [CH-1:0] pwm_out,
    output logic          step_pulse
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SAW  = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    localparam int          SW     = $clog2(STEP_DIV);
    localparam logic [R:0]  FULL   = {1'b1, {R{1'b0}}};
    localparam logic [SW-1:0] S_LAST = SW'(STEP_DIV - 1);
    localparam logic [SW-1:0] S_PRE  = SW'(STEP_DIV - 2);

    // Staggered start phase so channels are spread evenly across the duty range.
    function automatic logic [R:0] init_duty(input int k);
        int v;
        v = (k << R) / CH;
        return (R+1)'(v);
    endfunction

    mode_e            mode_s;
    logic [31:0]      q_r;
    logic             tick_s;
    logic [R-1:0]     d_r;
    logic [SW-1:0]    s_r;
    logic             step_pulse_r;
    logic [R:0]       hold_clamp_s;
    logic [R:0]       duty_r      [CH];
    logic [R:0]       duty_nxt_s  [CH];
    logic [CH-1:0]    dir_r;
    logic [CH-1:0]    dir_nxt_s;
    logic [R:0]       eff_duty_s  [CH];
    logic [CH-1:0]    pwm_r;

    assign mode_s = mode_e'(mode);

    // A count already past a newly lowered divisor wraps at once instead of running to 2^32.
    always_comb begin
        tick_s = (q_r >= dvsr);
    end

    // Prescaler and shared PWM period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 32'd0;
            d_r <= {R{1'b0}};
        end else if (tick_s) begin
            q_r <= 32'd0;
            d_r <= d_r + R'(1);
        end else begin
            q_r <= q_r + 32'd1;
        end
    end

    // Free-running step divider; the strobe is registered one count early so it lines up with s==STEP_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r          <= {SW{1'b0}};
            step_pulse_r <= 1'b0;
        end else begin
            step_pulse_r <= (s_r == S_PRE);
            if (s_r == S_LAST) begin
                s_r <= {SW{1'b0}};
            end else begin
                s_r <= s_r + SW'(1);
            end
        end
    end

    // Per-channel duty/direction update.
    always_comb begin
        hold_clamp_s = (hold_duty > FULL) ? FULL : hold_duty;
        dir_nxt_s    = dir_r;
        for (int k = 0; k < CH; k++) begin
            duty_nxt_s[k] = duty_r[k];
            case (mode_s)
                MODE_HOLD: begin
                    duty_nxt_s[k] = hold_clamp_s;
                end
                MODE_SAW: begin
                    if (step_pulse_r) begin
                        if (duty_r[k] == FULL) begin
                            duty_nxt_s[k] = {(R+1){1'b0}};
                        end else begin
                            duty_nxt_s[k] = duty_r[k] + (R+1)'(1);
                        end
                    end else begin
                        duty_nxt_s[k] = duty_r[k];
                    end
                end
                MODE_TRI: begin
                    // Turning points jump straight past the endpoint so peak and valley last one step.
                    if (!step_pulse_r) begin
                        duty_nxt_s[k] = duty_r[k];
                    end else if (dir_r[k]) begin
                        if (duty_r[k] == FULL) begin
                            dir_nxt_s[k]  = 1'b0;
                            duty_nxt_s[k] = FULL - (R+1)'(1);
                        end else begin
                            duty_nxt_s[k] = duty_r[k] + (R+1)'(1);
                        end
                    end else begin
                        if (duty_r[k] == {(R+1){1'b0}}) begin
                            dir_nxt_s[k]  = 1'b1;
                            duty_nxt_s[k] = (R+1)'(1);
                        end else begin
                            duty_nxt_s[k] = duty_r[k] - (R+1)'(1);
                        end
                    end
                end
                MODE_OFF: begin
                    duty_nxt_s[k] = init_duty(k);
                    dir_nxt_s[k]  = 1'b1;
                end
                default: begin
                    duty_nxt_s[k] = init_duty(k);
                    dir_nxt_s[k]  = 1'b1;
                end
            endcase
        end
    end

    // Duty and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                duty_r[k] <= init_duty(k);
            end
            dir_r <= {CH{1'b1}};
        end else begin
            for (int k = 0; k < CH; k++) begin
                duty_r[k] <= duty_nxt_s[k];
            end
            dir_r <= dir_nxt_s;
        end
    end

`ifdef PWM_FADER_GAMMA_EN
    // Square law with R-bit renormalisation keeps both endpoints exact (2^R*2^R >> R == 2^R).
    function automatic logic [R:0] gamma_map(input logic [R:0] x);
        logic [2*R+1:0] p;
        p = {{(R+1){1'b0}}, x} * {{(R+1){1'b0}}, x};
        return p[2*R:R];
    endfunction

    logic [R:0] eff_duty_r [CH];

    // Registered gamma stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                eff_duty_r[k] <= gamma_map(init_duty(k));
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                eff_duty_r[k] <= gamma_map(duty_r[k]);
            end
        end
    end

    // Expose the gamma register to the comparator.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            eff_duty_s[k] = eff_duty_r[k];
        end
    end
`else
    // Without gamma the comparator sees the duty register directly.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            eff_duty_s[k] = duty_r[k];
        end
    end
`endif

    // Output compare register; off mode forces the pins low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r <= {CH{1'b0}};
        end else begin
            for (int k = 0; k < CH; k++) begin
                pwm_r[k] <= (mode_s != MODE_OFF) && ({1'b0, d_r} < eff_duty_s[k]);
            end
        end
    end

    assign pwm_out    = pwm_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_pwm_fader_multi.sv
// Scoreboard bench for pwm_fader_multi (CH=4, R=8, STEP_DIV=4): directed scenarios push
// expected per-cycle pwm_out/step_pulse; a negedge monitor pops and compares.
module tb_pwm_fader_multi;

    localparam int CH   = 4;
    localparam int R    = 8;
    localparam int SD   = 4;
    localparam int MAXK = 2400;
    localparam int INIT [CH] = '{0, 64, 128, 192};
`ifdef PWM_FADER_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   dvsr;
    logic [1:0]    mode;
    logic [R:0]    hold_duty;
    logic [CH-1:0] pwm_out;
    logic          step_pulse;

    always #5 clk = ~clk;

    pwm_fader_multi #(.CH(CH), .R(R), .STEP_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .dvsr       (dvsr),
        .mode       (mode),
        .hold_duty  (hold_duty),
        .pwm_out    (pwm_out),
        .step_pulse (step_pulse)
    );

    typedef struct {
        int            cyc;
        int            k;
        int            sid;
        logic [CH-1:0] pwm;
        logic          stp;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         d_tab  [MAXK+1];
    int         dv_tab [MAXK+1];
    logic [1:0] md_tab [MAXK+1];
    int         duty_tab [CH][MAXK+1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sname(input int id);
        case (id)
            0: return "off";
            1: return "hold_mid";
            2: return "hold_clamp";
            3: return "hold_zero";
            4: return "dvsr_change";
            5: return "sawtooth";
            6: return "triangle_off";
            7: return "after_rst";
            default: return "unknown";
        endcase
    endfunction

    function automatic int tri_of(input int p);
        int m;
        m = p % 512;
        return (m <= 256) ? m : 512 - m;
    endfunction

    function automatic int gam(input int x);
        return (x * x) >> 8;
    endfunction

    task automatic fill_d_const(input int dv, input int n);
        for (int k = 0; k <= n; k++) begin
            dv_tab[k] = dv;
            d_tab[k]  = (k / (dv + 1)) % 256;
        end
    endtask

    task automatic run_scn(input int id, input int n, input int hdv);
        int   n0;
        int   phase [CH];
        int   eff;
        int   j;
        exp_t e;
        rst       = 1'b1;
        mode      = md_tab[0];
        dvsr      = 32'(dv_tab[0]);
        hold_duty = (R+1)'(hdv);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n0  = cyc;
        for (int c = 0; c < CH; c++) begin
            phase[c]       = INIT[c];
            duty_tab[c][0] = INIT[c];
        end
        // Duty after edge k, driven by the mode during cycle k-1; steps land on edges k%4==0.
        for (int k = 1; k <= n; k++) begin
            for (int c = 0; c < CH; c++) begin
                case (md_tab[k-1])
                    2'b11: begin
                        phase[c]       = INIT[c];
                        duty_tab[c][k] = INIT[c];
                    end
                    2'b00: duty_tab[c][k] = (hdv > 256) ? 256 : hdv;
                    2'b01: begin
                        if ((k - 1) % SD == SD - 1) phase[c] = (phase[c] + 1) % 257;
                        duty_tab[c][k] = phase[c];
                    end
                    default: begin
                        if ((k - 1) % SD == SD - 1) phase[c] = phase[c] + 1;
                        duty_tab[c][k] = tri_of(phase[c]);
                    end
                endcase
            end
        end
        for (int k = 0; k <= n; k++) begin
            e.cyc = n0 + k;
            e.k   = k;
            e.sid = id;
            e.stp = (k % SD == SD - 1);
            e.pwm = '0;
            if (k > 0 && md_tab[k-1] != 2'b11) begin
                j = k - 1;
                for (int c = 0; c < CH; c++) begin
                    if (GAMMA) eff = gam((j == 0) ? INIT[c] : duty_tab[c][j-1]);
                    else       eff = duty_tab[c][j];
                    e.pwm[c] = (d_tab[j] < eff);
                end
            end
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            mode = md_tab[k];
            dvsr = 32'(dv_tab[k]);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare the entry queued for this cycle, flag any entry that was skipped.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s k=%0d missed: entry for cycle %0d not checked", sname(mon_e.sid), mon_e.k, mon_e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            n_tests = n_tests + 2;
            if (pwm_out !== mon_e.pwm) begin
                n_fail = n_fail + 1;
                $display("FAIL %s k=%0d pwm_out got %b expected %b", sname(mon_e.sid), mon_e.k, pwm_out, mon_e.pwm);
            end
            if (step_pulse !== mon_e.stp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s k=%0d step_pulse got %b expected %b", sname(mon_e.sid), mon_e.k, step_pulse, mon_e.stp);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mode      = 2'b11;
        dvsr      = 32'd0;
        hold_duty = '0;
        repeat (2) @(posedge clk);
        #1;

        fill_d_const(0, 39);
        for (int k = 0; k <= 39; k++) md_tab[k] = 2'b11;
        run_scn(0, 39, 0);

        fill_d_const(0, 519);
        for (int k = 0; k <= 519; k++) md_tab[k] = 2'b00;
        run_scn(1, 519, GAMMA ? 128 : 64);

        fill_d_const(0, 43);
        for (int k = 0; k <= 43; k++) md_tab[k] = 2'b00;
        run_scn(2, 43, 300);
        run_scn(3, 43, 0);

        // Divisor lowered from 100 to 2 while q==5: immediate wrap, then a tick every 3 cycles.
        for (int k = 0; k <= 23; k++) begin
            md_tab[k] = 2'b00;
            dv_tab[k] = (k < 5) ? 100 : 2;
            d_tab[k]  = (k <= 5) ? 0 : 1 + (k - 6) / 3;
        end
        run_scn(4, 23, 2);

        fill_d_const(0, 1103);
        for (int k = 0; k <= 1103; k++) md_tab[k] = 2'b01;
        run_scn(5, 1103, 0);

        // Triangle with an off window starting on a step cycle; the run ends with rst on a step cycle.
        fill_d_const(0, 2399);
        for (int k = 0; k <= 2399; k++) md_tab[k] = (k >= 283 && k <= 290) ? 2'b11 : 2'b10;
        run_scn(6, 2399, 0);

        fill_d_const(0, 15);
        for (int k = 0; k <= 15; k++) md_tab[k] = 2'b01;
        run_scn(7, 15, 0);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fader_multi.md
# pwm_fader_multi

Multi-channel successor to the single-channel linear fade generator. It produces CH PWM outputs from one shared prescaled period counter. Each channel has its own duty register, automatically stepped in sawtooth or triangle fashion, or held at a host-supplied value. It sits between the board clock and the LED/output pins, and an optional gamma stage linearises perceived brightness.

## Interface
- CH, 4, number of PWM channels (1..16)
- R, 8, PWM resolution in bits; duty range 0..2^R inclusive
- STEP_DIV, 2_500_000, clk cycles between duty steps (≥2)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- dvsr  in  32  prescaler divisor; PWM tick every dvsr+1 clk cycles
- mode  in  2  00 hold, 01 sawtooth, 10 triangle, 11 off
- hold_duty  in  R+1  duty applied to all channels in hold mode
- pwm_out  out  CH  PWM outputs, bit k = channel k
- step_pulse  out  1  one-cycle strobe on each duty step

## Operation
- Prescaler q (32 b):
  - counts 0..dvsr; tick=1 in the cycle q==dvsr, then q returns to 0.
  - dvsr=0 gives tick every cycle.
  - dvsr changed mid-count: if q>dvsr, q wraps to 0 next cycle with tick=1.
- PWM counter d (R b): increments on tick, wraps 2^R-1→0.
- Compare: pwm_out[k] <= (d < eff_duty[k]).
  - eff_duty = 0 gives constant low.
  - eff_duty = 2^R gives constant high.
- Step counter s: counts 0..STEP_DIV-1; step_pulse=1 in the cycle s==STEP_DIV-1, then s returns to 0. Free-running in every mode.
- Per-channel state: duty[k] (R+1 b) and dir[k] (1=up).
- Reset/initial phase: duty[k] = (k·2^R)/CH (integer division), dir[k]=1.
- Sawtooth (01), on step_pulse:
  - duty[k] == 2^R → 0; otherwise duty[k]+1.
  - dir ignored and unchanged.
- Triangle (10), on step_pulse:
  - dir=1 and duty<2^R → duty+1.
  - dir=1 and duty==2^R → dir=0, duty=2^R-1.
  - dir=0 and duty>0 → duty-1.
  - dir=0 and duty==0 → dir=1, duty=1.
  - Peak and valley each last exactly one step.
- Hold (00):
  - Every cycle duty[k] <= min(hold_duty, 2^R).
  - dir unchanged.
  - step_pulse is still generated.
- Off (11):
  - Every cycle duty[k] and dir[k] are reloaded to the initial phase.
  - pwm_out forced 0 next cycle.
  - q and d keep running.
- Mode switches take effect on the next clock edge. Duty and dir carry over between hold, sawtooth and triangle with no reload.
- Sawtooth→triangle with duty==2^R and dir=1 turns down on the first step.

## Timing
- Reset values:
  - pwm_out=0, step_pulse=0, q=0, d=0, s=0.
  - duty and dir at initial phase.
- pwm_out is registered: 1-cycle latency from d/duty state to pin.
- A duty update at step_pulse is visible on pwm_out at the second clk edge after step_pulse (duty register, then output register).
  - With gamma enabled, add 1 cycle (registered gamma).
- PWM period = (dvsr+1)·2^R clk cycles.
- Full sawtooth sweep = (2^R+1)·STEP_DIV cycles.
- Full triangle period = 2·2^R·STEP_DIV cycles.
- rst asserted mid-operation overrides everything in the same edge, including any coincident step_pulse or mode change.

## Configuration
- PWM_FADER_GAMMA_EN defined:
  - eff_duty[k] = (duty[k]·duty[k]) >> R, computed in 2R+2 bits and registered.
  - Endpoints 0→0 and 2^R→2^R are exact.
  - Example, R=8: duty 128 → 64, duty 16 → 1.
- Not defined: eff_duty[k] = duty[k] combinationally, with no extra latency.

## Test plan
- Reset, CH=4, R=8, mode=11: duty = 0, 64, 128, 192; pwm_out=0 throughout; step_pulse toggles every STEP_DIV cycles.
- Hold, dvsr=0, hold_duty=64:
  - each pwm_out high exactly 64 of 256 cycles per period, all channels in phase.
  - hold_duty=300: clamped to 256, all outputs constant high.
  - hold_duty=0: constant low.
- Sawtooth, STEP_DIV=4, dvsr=0:
  - channel 3 goes 192→256→0 across successive steps.
  - step_pulse period is 4 cycles.
  - full 0..256 sweep of ch0 takes 257 steps.
- Triangle, STEP_DIV=4: ch0 sequence 0,1,…,256,255,…,0,1; 256 and 0 each appear exactly once per turn.
- Mid-run rst, and a mode change 10→11 in the same cycle as step_pulse:
  - after rst: all state equals the reset values.
  - after the mode change: duties reload to 0/64/128/192 and pwm_out=0 next cycle.
- With PWM_FADER_GAMMA_EN, hold_duty=128, R=8, dvsr=0: high time 64 of 256 cycles; hold_duty=256 gives constant high.
